// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, register
// indices, FSM states and instruction field positions.
package regfile_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_MOV  = 4'h5,
    OP_MOVI = 4'h6,
    OP_ADDI = 4'h7,
    OP_LSL  = 4'h8,
    OP_LSR  = 4'h9,
    OP_CMP  = 4'hA
  } opcode_t;

  typedef enum logic [3:0] {
    R1  = 4'd1,
    R2  = 4'd2,
    R3  = 4'd3,
    R4  = 4'd4,
    R5  = 4'd5,
    R6  = 4'd6,
    R7  = 4'd7,
    R8  = 4'd8,
    CMP = 4'd9,
    SP  = 4'd10
  } reg_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned RDST_MSB = 11;
  localparam int unsigned RDST_LSB = 8;
  localparam int unsigned RSRC_MSB = 7;
  localparam int unsigned RSRC_LSB = 4;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

  function automatic logic op_defined(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

  // Immediate forms reuse the rsrc bits, so rsrc is not range-checked there.
  function automatic logic op_uses_rsrc(input logic [3:0] op);
    return !(op == OP_MOVI || op == OP_ADDI);
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake plus register-file port bundle; master is the
// sequencer side, slave is the host / register-file side.
interface regfile_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic [15:0]       in_instr;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rf_reg1;
  logic [ADDR_W-1:0] rf_reg2;
  logic [DATA_W-1:0] rf_data_in;
  logic              rf_write;
  logic [DATA_W-1:0] rf_r1_data;
  logic [DATA_W-1:0] rf_r2_data;

  modport master (
    input  in_instr, in_valid, rf_r1_data, rf_r2_data,
    output in_ready, rf_reg1, rf_reg2, rf_data_in, rf_write
  );

  modport slave (
    output in_instr, in_valid, rf_r1_data, rf_r2_data,
    input  in_ready, rf_reg1, rf_reg2, rf_data_in, rf_write
  );
endinterface

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU: result and {N,Z,C,V}; CMP returns the flag word as
// its result so the write-back path needs no special case for data.
module regfile_ctrl_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        imm,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              c;
  logic              v;

  assign imm_sx = {{(DATA_W-8){imm[7]}}, imm};
  assign imm_zx = {{(DATA_W-8){1'b0}}, imm};

  always_comb begin
    opb = b;
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        opb = (op == OP_ADDI) ? imm_sx : b;
        sum = {1'b0, a} + {1'b0, opb};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[MSB] == opb[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        res = a - b;
        c   = a < b;
        v   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MOV:  res = b;
      OP_MOVI: res = imm_zx;
      OP_LSL:  res = a << b[3:0];
      OP_LSR:  res = a >> b[3:0];
      default: res = '0;
    endcase
    flags  = {res[MSB], (res == '0), c, v};
    result = (op == OP_CMP) ? {{(DATA_W-4){1'b0}}, flags} : res;
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) executing one register-to-register
// instruction per handshake against an external register file.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MAX_REG = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_ctrl_if.master       bus,
  output logic                 done,
  output logic                 err,
  output logic [3:0]           flags
);

  localparam logic [ADDR_W-1:0] MAX_REG_A = ADDR_W'(MAX_REG);

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic [3:0]        op;
  logic [3:0]        rdst;
  logic [3:0]        rsrc;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] rdst_a;
  logic [ADDR_W-1:0] rsrc_a;
  logic              rdst_ok;
  logic              rsrc_ok;
  logic              legal;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;

  assign op     = instr_q[OP_MSB:OP_LSB];
  assign rdst   = instr_q[RDST_MSB:RDST_LSB];
  assign rsrc   = instr_q[RSRC_MSB:RSRC_LSB];
  assign imm    = instr_q[IMM_MSB:IMM_LSB];
  assign rdst_a = ADDR_W'(rdst);
  assign rsrc_a = ADDR_W'(rsrc);

  assign rdst_ok = (rdst_a != '0) && (rdst_a <= MAX_REG_A);
  assign rsrc_ok = (rsrc_a != '0) && (rsrc_a <= MAX_REG_A);
  assign legal   = op_defined(op) && rdst_ok && (rsrc_ok || !op_uses_rsrc(op));

  regfile_ctrl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    flags_d        = flags_q;
    bus.in_ready   = 1'b0;
    bus.rf_reg1    = '0;
    bus.rf_reg2    = '0;
    bus.rf_data_in = '0;
    bus.rf_write   = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          instr_d = bus.in_instr;
          state_d = READ;
        end
      end
      READ: begin
        bus.rf_reg1 = rdst_a;
        bus.rf_reg2 = rsrc_a;
        if (!legal) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          a_d     = bus.rf_r1_data;
          b_d     = bus.rf_r2_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flags_d  = alu_flags;
        state_d  = WB;
      end
      WB: begin
        bus.rf_write   = 1'b1;
        bus.rf_reg1    = (op == OP_CMP) ? ADDR_W'(CMP) : rdst_a;
        bus.rf_data_in = result_q;
        done           = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: a behavioural register file and
// instruction model predict every write-back / error pulse.
module tb_regfile_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done;
  logic       err;
  logic [3:0] flags;

  regfile_ctrl_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  regfile_ctrl #(
    .DATA_W  (16),
    .ADDR_W  (5),
    .MAX_REG (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .done  (done),
    .err   (err),
    .flags (flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural register file, written only by the DUT or by preload.
  logic [15:0] rf_mem [32] = '{default: '0};
  logic        pre_en = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign bus.rf_r1_data = rf_mem[bus.rf_reg1];
  assign bus.rf_r2_data = rf_mem[bus.rf_reg2];

  always @(posedge clk) begin
    if (pre_en) rf_mem[pre_addr] <= pre_data;
    else if (bus.rf_write) rf_mem[bus.rf_reg1] <= bus.rf_data_in;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int addr;
    int data;
    int flags;
  } exp_t;

  exp_t exp_q[$];
  int   accept_q[$];
  int   accept_log[$];
  int   sh[32] = '{default: 0};
  int   mflags = 0;
  int   ready_at = -1;

  function automatic int s16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic push_expect(input logic [15:0] ins);
    exp_t e;
    int op, rd, rs, imm, a, b, r, sr, r16;
    bit c, v, n, z, legal;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:8]);
    rs  = int'(ins[7:4]);
    imm = int'(ins[7:0]);
    a   = sh[rd];
    b   = sh[rs];
    c = 0; v = 0; r = 0; sr = 0;
    legal = (op <= 10) && (rd >= 1) && (rd <= 10) &&
            ((op == 6) || (op == 7) || ((rs >= 1) && (rs <= 10)));
    case (op)
      0:  begin r = a + b; c = (r > 65535); sr = s16(a) + s16(b); end
      1, 10: begin r = a - b; c = (a < b); sr = s16(a) - s16(b); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = b;
      6:  r = imm;
      7:  begin
            r  = a + ((imm >= 128) ? imm + 65280 : imm);
            c  = (r > 65535);
            sr = s16(a) + ((imm >= 128) ? imm - 256 : imm);
          end
      8:  r = a << (b % 16);
      9:  r = a >> (b % 16);
      default: r = 0;
    endcase
    if (op == 0 || op == 1 || op == 7 || op == 10) v = (sr > 32767) || (sr < -32768);
    r16 = r & 65535;
    n = (r16 >= 32768);
    z = (r16 == 0);
    e.is_err = !legal;
    if (legal) begin
      mflags = {28'b0, n, z, c, v};
      e.addr = (op == 10) ? 9 : rd;
      e.data = (op == 10) ? mflags : r16;
      sh[e.addr] = e.data;
    end else begin
      e.addr = 0;
      e.data = 0;
    end
    e.flags = mflags;
    exp_q.push_back(e);
  endtask

  // Monitor: everything sampled on the falling edge.
  exp_t e_mon;
  int   t0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.in_ready && bus.in_valid) begin
        accept_q.push_back(cyc);
        accept_log.push_back(cyc);
      end
      if (bus.rf_write || done || err) begin
        chk("done_err_excl", int'(done & err), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          t0 = -100;
          if (accept_q.size() != 0) t0 = accept_q.pop_front();
          if (e_mon.is_err) begin
            chk("err", int'(err), 1);
            chk("err_no_write", int'(bus.rf_write), 0);
            chk("err_latency", cyc - t0, 1);
            chk("flags_held", int'(flags), e_mon.flags);
          end else begin
            chk("done", int'(done), 1);
            chk("write", int'(bus.rf_write), 1);
            chk("wr_addr", int'(bus.rf_reg1), e_mon.addr);
            chk("wr_data", int'(bus.rf_data_in), e_mon.data);
            chk("flags", int'(flags), e_mon.flags);
            chk("wb_latency", cyc - t0, 3);
          end
          ready_at = cyc + 1;
        end
      end
      if (cyc == ready_at) chk("ready_after", int'(bus.in_ready), 1);
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic [15:0] ins, input bit hold, input bit track);
    int n = 0;
    bus.in_instr = ins;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("issue_timeout", 0, 1);
    if (track) push_expect(ins);
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic preload(input int addr, input int data);
    pre_en   = 1'b1;
    pre_addr = 5'(addr);
    pre_data = 16'(data);
    sh[addr] = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] ins;
    bus.in_instr = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_rf_write", int'(bus.rf_write), 0);
    chk("rst_rf_reg1", int'(bus.rf_reg1), 0);
    chk("rst_rf_reg2", int'(bus.rf_reg2), 0);
    chk("rst_rf_data_in", int'(bus.rf_data_in), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_flags", int'(flags), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    issue(16'h617F, 0, 1);
    drain();

    preload(1, 16'h7FFF);
    preload(2, 16'h0001);
    issue(16'h0112, 0, 1);
    drain();

    preload(3, 16'h1234);
    preload(4, 16'h1234);
    issue(16'hA340, 0, 1);
    drain();
    chk("cmp_r3_unchanged", int'(rf_mem[3]), 16'h1234);
    chk("cmp_reg9", int'(rf_mem[9]), 16'h0004);

    issue(16'h0012, 0, 1);
    drain();
    issue(16'h01C0, 0, 1);
    drain();
    issue(16'hC120, 0, 1);
    drain();

    preload(5, 16'hFFFF);
    accept_log.delete();
    issue(16'h7501, 1, 1);
    issue(16'h7501, 1, 1);
    issue(16'h7501, 0, 1);
    drain();
    chk("b2b_accepts", accept_log.size(), 3);
    if (accept_log.size() == 3) begin
      chk("b2b_gap1", accept_log[1] - accept_log[0], 4);
      chk("b2b_gap2", accept_log[2] - accept_log[1], 4);
    end
    chk("b2b_r5", int'(rf_mem[5]), 16'h0002);

    // Abort an ADD in EXEC; it must leave no trace.
    preload(1, 16'h1111);
    preload(2, 16'h2222);
    issue(16'h0112, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_rf_write", int'(bus.rf_write), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_flags", int'(flags), 0);
    mflags = 0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    accept_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_target", int'(rf_mem[1]), 16'h1111);
    issue(16'h0112, 0, 1);
    drain();

    for (int i = 0; i < 24; i++) begin
      ins[15:12] = 4'($urandom_range(0, 15));
      ins[11:8]  = 4'($urandom_range(0, 11));
      ins[7:0]   = 8'($urandom_range(0, 255));
      if (i % 3 == 0) preload(int'($urandom_range(1, 10)), int'($urandom_range(0, 65535)));
      issue(ins, 0, 1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
